// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode / register-read stage feeding execute
// Decodes one instruction per cycle, interlocks on pending destinations, owns the register file.
module id_stage #(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 16,
  parameter int REG_NUM = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_v_i,
  input  logic [31:0]       inst_i,
  input  logic [PC_W-1:0]   pc_i,
  output logic              stall_o,
  input  logic              stall_i,
  input  logic              branch_en_i,
  input  logic              wb_en_i,
  input  logic [3:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] rd_value_o,
  output logic [DATA_W-1:0] rs_value_o,
  output logic [DATA_W-1:0] imm_value_o,
  output logic [3:0]        rd_addr_o,
  output logic [PC_W-1:0]   pc_value_o,
  output logic [6:0]        opcode_o,
  output logic              ctrl_inte_o,
  output logic              ctrl_logic_o,
  output logic              ctrl_shift_o,
  output logic              ctrl_ld_o,
  output logic              ctrl_st_o,
  output logic              ctrl_br_o,
  output logic              immf_o,
  output logic              rsv_o
);

  logic [6:0]  opcode;
  logic [3:0]  rd_a;
  logic [3:0]  rs_a;
  logic        immf;
  logic [15:0] imm16;
  logic [2:0]  cls;

  assign opcode = inst_i[31:25];
  assign rd_a   = inst_i[24:21];
  assign rs_a   = inst_i[20:17];
  assign immf   = inst_i[16];
  assign imm16  = inst_i[15:0];
  assign cls    = opcode[6:4];

  logic c_inte, c_logic, c_shift, c_ld, c_st, c_br, class_ok, rsv;
  assign c_inte   = (cls == 3'd0);
  assign c_logic  = (cls == 3'd1);
  assign c_shift  = (cls == 3'd2);
  assign c_ld     = (cls == 3'd3);
  assign c_st     = (cls == 3'd4);
  assign c_br     = (cls == 3'd5);
  assign class_ok = c_inte | c_logic | c_shift | c_ld | c_st | c_br;
  assign rsv      = c_inte | c_logic | c_shift | c_ld;

  logic [DATA_W-1:0] imm_ext;
  assign imm_ext = c_logic ? {{(DATA_W-16){1'b0}}, imm16}
                           : {{(DATA_W-16){imm16[15]}}, imm16};

  // Register file with write-to-read bypass so a same-cycle write-back is visible
  logic [DATA_W-1:0] rf_q [REG_NUM];
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;
  logic              wb_hit_rd;
  logic              wb_hit_rs;

  assign wb_hit_rd = wb_en_i && (wb_addr_i == rd_a);
  assign wb_hit_rs = wb_en_i && (wb_addr_i == rs_a);
  assign rd_val    = wb_hit_rd ? wb_data_i : rf_q[rd_a];
  assign rs_val    = wb_hit_rs ? wb_data_i : rf_q[rs_a];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) rf_q[i] <= '0;
    end else if (wb_en_i) begin
      rf_q[wb_addr_i] <= wb_data_i;
    end
  end

  logic [REG_NUM-1:0] pending_q;
  logic [REG_NUM-1:0] pending_d;
  logic               rd_busy;
  logic               rs_busy;
  logic               hazard;
  logic               issue;

  // rd is always a source: execute reads it as operand 0 and as the branch condition
  assign rd_busy = pending_q[rd_a] & ~wb_hit_rd;
  assign rs_busy = pending_q[rs_a] & ~wb_hit_rs;
  assign hazard  = class_ok & (rd_busy | (~immf & rs_busy));
  assign issue   = inst_v_i & ~stall_i & ~hazard & ~branch_en_i & class_ok;
  assign stall_o = rst & inst_v_i & ~branch_en_i & (stall_i | hazard);

  always_comb begin
    pending_d = pending_q;
    if (wb_en_i) pending_d[wb_addr_i] = 1'b0;
    if (issue && rsv) pending_d[rd_a] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  logic [DATA_W-1:0] rd_value_q, rs_value_q, imm_value_q;
  logic [3:0]        rd_addr_q;
  logic [PC_W-1:0]   pc_value_q;
  logic [6:0]        opcode_q;
  logic [5:0]        ctrl_q;
  logic              immf_q, rsv_q;

  // Execute never holds, so anything not issued becomes an all-zero bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_value_q  <= '0;
      rs_value_q  <= '0;
      imm_value_q <= '0;
      rd_addr_q   <= '0;
      pc_value_q  <= '0;
      opcode_q    <= '0;
      ctrl_q      <= '0;
      immf_q      <= 1'b0;
      rsv_q       <= 1'b0;
    end else if (issue) begin
      rd_value_q  <= rd_val;
      rs_value_q  <= rs_val;
      imm_value_q <= imm_ext;
      rd_addr_q   <= rd_a;
      pc_value_q  <= pc_i;
      opcode_q    <= opcode;
      ctrl_q      <= {c_inte, c_logic, c_shift, c_ld, c_st, c_br};
      immf_q      <= immf;
      rsv_q       <= rsv;
    end else begin
      rd_value_q  <= '0;
      rs_value_q  <= '0;
      imm_value_q <= '0;
      rd_addr_q   <= '0;
      pc_value_q  <= '0;
      opcode_q    <= '0;
      ctrl_q      <= '0;
      immf_q      <= 1'b0;
      rsv_q       <= 1'b0;
    end
  end

  assign rd_value_o   = rd_value_q;
  assign rs_value_o   = rs_value_q;
  assign imm_value_o  = imm_value_q;
  assign rd_addr_o    = rd_addr_q;
  assign pc_value_o   = pc_value_q;
  assign opcode_o     = opcode_q;
  assign ctrl_inte_o  = ctrl_q[5];
  assign ctrl_logic_o = ctrl_q[4];
  assign ctrl_shift_o = ctrl_q[3];
  assign ctrl_ld_o    = ctrl_q[2];
  assign ctrl_st_o    = ctrl_q[1];
  assign ctrl_br_o    = ctrl_q[0];
  assign immf_o       = immf_q;
  assign rsv_o        = rsv_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage
// Expected execute-side outputs are queued as stimulus is driven and compared one edge later.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_v_i;
  logic [31:0] inst_i;
  logic [15:0] pc_i;
  logic        stall_o;
  logic        stall_i;
  logic        branch_en_i;
  logic        wb_en_i;
  logic [3:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] rd_value_o, rs_value_o, imm_value_o;
  logic [3:0]  rd_addr_o;
  logic [15:0] pc_value_o;
  logic [6:0]  opcode_o;
  logic        ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o;
  logic        immf_o, rsv_o;

  id_stage dut (
    .clk(clk), .rst(rst), .inst_v_i(inst_v_i), .inst_i(inst_i), .pc_i(pc_i),
    .stall_o(stall_o), .stall_i(stall_i), .branch_en_i(branch_en_i),
    .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .rd_value_o(rd_value_o), .rs_value_o(rs_value_o), .imm_value_o(imm_value_o),
    .rd_addr_o(rd_addr_o), .pc_value_o(pc_value_o), .opcode_o(opcode_o),
    .ctrl_inte_o(ctrl_inte_o), .ctrl_logic_o(ctrl_logic_o), .ctrl_shift_o(ctrl_shift_o),
    .ctrl_ld_o(ctrl_ld_o), .ctrl_st_o(ctrl_st_o), .ctrl_br_o(ctrl_br_o),
    .immf_o(immf_o), .rsv_o(rsv_o)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_INTE  = 7'h01;
  localparam logic [6:0] OP_LOGIC = 7'h12;
  localparam logic [6:0] OP_ST    = 7'h40;
  localparam logic [6:0] OP_BR    = 7'h50;
  localparam logic [6:0] OP_BAD   = 7'h60;

  typedef struct {
    logic [6:0]  op;
    logic [3:0]  rd;
    logic [31:0] rdv;
    logic [31:0] rsv;
    logic [31:0] imm;
    logic [15:0] pc;
    logic [5:0]  ctrl;
    logic        immf;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s step %0d observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [3:0] rd,
                                     input logic [3:0] rs, input logic f,
                                     input logic [15:0] imm);
    return {op, rd, rs, f, imm};
  endfunction

  function automatic exp_t bub();
    exp_t e;
    e.op = '0; e.rd = '0; e.rdv = '0; e.rsv = '0; e.imm = '0;
    e.pc = '0; e.ctrl = '0; e.immf = 1'b0; e.wr = 1'b0;
    return e;
  endfunction

  function automatic exp_t iss(input logic [6:0] op, input logic [3:0] rd,
                               input logic [31:0] rdv, input logic [31:0] rsv,
                               input logic [31:0] imm, input logic [15:0] pc,
                               input logic immf);
    exp_t e;
    e.op = op; e.rd = rd; e.rdv = rdv; e.rsv = rsv; e.imm = imm;
    e.pc = pc; e.immf = immf;
    e.ctrl = 6'b100000 >> op[6:4];
    e.wr = (op[6:4] <= 3'd3);
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("opcode",   {25'd0, opcode_o}, {25'd0, e.op});
    check("rd_addr",  {28'd0, rd_addr_o}, {28'd0, e.rd});
    check("rd_value", rd_value_o, e.rdv);
    check("rs_value", rs_value_o, e.rsv);
    check("imm",      imm_value_o, e.imm);
    check("pc",       {16'd0, pc_value_o}, {16'd0, e.pc});
    check("ctrl", {26'd0, ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o},
          {26'd0, e.ctrl});
    check("immf", {31'd0, immf_o}, {31'd0, e.immf});
    check("rsv",  {31'd0, rsv_o}, {31'd0, e.wr});
  endtask

  task automatic step(input logic iv, input logic [31:0] ins, input logic [15:0] pc,
                      input logic st, input logic br, input logic we,
                      input logic [3:0] wa, input logic [31:0] wd,
                      input logic exp_stall, input exp_t e);
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) compare(exp_q.pop_front());
    inst_v_i = iv; inst_i = ins; pc_i = pc; stall_i = st; branch_en_i = br;
    wb_en_i = we; wb_addr_i = wa; wb_data_i = wd;
    #1;
    check("stall_o", {31'd0, stall_o}, {31'd0, exp_stall});
    exp_q.push_back(e);
  endtask

  task automatic idle_wb(input logic [3:0] wa, input logic [31:0] wd);
    step(1'b0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b1, wa, wd, 1'b0, bub());
  endtask

  initial begin
    rst = 1'b0; inst_v_i = 1'b0; inst_i = '0; pc_i = '0; stall_i = 1'b0;
    branch_en_i = 1'b0; wb_en_i = 1'b0; wb_addr_i = '0; wb_data_i = '0;
    repeat (2) @(negedge clk);
    check("reset_rd_value", rd_value_o, 32'd0);
    check("reset_opcode", {25'd0, opcode_o}, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    rst = 1'b1;

    // write-back then read
    idle_wb(4'd5, 32'h1234_5678);
    step(1, mk(OP_INTE, 5, 2, 0, 16'h0010), 16'h0100, 0, 0, 0, 0, 0, 0,
         iss(OP_INTE, 5, 32'h1234_5678, 0, 32'h10, 16'h0100, 0));
    idle_wb(4'd5, 32'h0000_AAAA);

    // RAW interlock resolved by the write-back bypass
    step(1, mk(OP_INTE, 1, 0, 1, 16'h0007), 16'h0104, 0, 0, 0, 0, 0, 0,
         iss(OP_INTE, 1, 0, 0, 32'h7, 16'h0104, 1));
    step(1, mk(OP_LOGIC, 2, 1, 0, 16'hFFFE), 16'h0108, 0, 0, 0, 0, 0, 1, bub());
    step(1, mk(OP_LOGIC, 2, 1, 0, 16'hFFFE), 16'h0108, 0, 0, 1, 4'd1, 32'h55, 0,
         iss(OP_LOGIC, 2, 0, 32'h55, 32'h0000_FFFE, 16'h0108, 0));

    // sign extension; pending rs ignored with an immediate operand
    step(1, mk(OP_INTE, 3, 2, 1, 16'hFFFE), 16'h010C, 0, 0, 0, 0, 0, 0,
         iss(OP_INTE, 3, 0, 0, 32'hFFFF_FFFE, 16'h010C, 1));
    idle_wb(4'd2, 32'h22);
    idle_wb(4'd3, 32'h33);

    // branch: issue, stall bubble, squash
    step(1, mk(OP_BR, 1, 0, 1, 16'h0004), 16'h0110, 0, 0, 0, 0, 0, 0,
         iss(OP_BR, 1, 32'h55, 0, 32'h4, 16'h0110, 1));
    step(1, mk(OP_INTE, 6, 0, 1, 16'h0000), 16'h0114, 1, 0, 0, 0, 0, 1, bub());
    step(1, mk(OP_INTE, 6, 0, 1, 16'h0000), 16'h0114, 1, 1, 0, 0, 0, 0, bub());
    step(1, mk(OP_INTE, 6, 6, 0, 16'h0000), 16'h0200, 0, 0, 0, 0, 0, 0,
         iss(OP_INTE, 6, 0, 0, 0, 16'h0200, 0));
    idle_wb(4'd6, 32'h66);

    // simultaneous set and clear of r4
    step(1, mk(OP_INTE, 4, 0, 1, 16'h0000), 16'h0204, 0, 0, 0, 0, 0, 0,
         iss(OP_INTE, 4, 0, 0, 0, 16'h0204, 1));
    step(1, mk(OP_INTE, 4, 0, 1, 16'h0001), 16'h0208, 0, 0, 1, 4'd4, 32'h44, 0,
         iss(OP_INTE, 4, 32'h44, 0, 32'h1, 16'h0208, 1));
    for (int i = 0; i < 2; i++)
      step(1, mk(OP_LOGIC, 7, 4, 0, 16'h0000), 16'h020C, 0, 0, 0, 0, 0, 1, bub());
    step(1, mk(OP_LOGIC, 7, 4, 0, 16'h0000), 16'h020C, 0, 0, 1, 4'd4, 32'h99, 0,
         iss(OP_LOGIC, 7, 0, 32'h99, 0, 16'h020C, 0));

    // reserved class is consumed as a bubble without stalling
    step(1, mk(OP_BAD, 7, 7, 0, 16'h1234), 16'h0210, 0, 0, 0, 0, 0, 0, bub());
    idle_wb(4'd7, 32'h77);
    step(1, mk(OP_ST, 1, 0, 1, 16'h8000), 16'h0220, 0, 0, 0, 0, 0, 0,
         iss(OP_ST, 1, 32'h55, 0, 32'hFFFF_8000, 16'h0220, 1));
    step(1, mk(OP_INTE, 3, 0, 1, 16'h0000), 16'h0300, 0, 0, 0, 0, 0, 0,
         iss(OP_INTE, 3, 32'h33, 0, 0, 16'h0300, 1));

    // reset mid-stream with r3 pending
    @(negedge clk);
    cyc++;
    compare(exp_q.pop_front());
    rst = 1'b0; inst_v_i = 1'b1; inst_i = mk(OP_INTE, 5, 3, 0, 16'h0000);
    stall_i = 1'b1; wb_en_i = 1'b0;
    #1;
    check("rst_rd_value", rd_value_o, 32'd0);
    check("rst_pc", {16'd0, pc_value_o}, 32'd0);
    check("rst_ctrl", {31'd0, ctrl_inte_o}, 32'd0);
    check("rst_rsv", {31'd0, rsv_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1; inst_v_i = 1'b0; stall_i = 1'b0;
    step(1, mk(OP_INTE, 3, 3, 0, 16'h0000), 16'h0304, 0, 0, 0, 0, 0, 0,
         iss(OP_INTE, 3, 0, 0, 0, 16'h0304, 0));
    step(0, 32'd0, 16'd0, 0, 0, 0, 0, 0, 0, bub());
    @(negedge clk);
    cyc++;
    compare(exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Decode / register-read stage directly upstream of the execute stage.
- Takes one 32-bit instruction from fetch, decodes it into the execute stage's control inputs, reads the 16x32 register file and drives registered operands to execute.
- Owns the register file write port, fed back from execute's write-back outputs.
- Interlocks on pending destination registers, inserts bubbles while execute stalls for a branch, and squashes on a taken branch.

Parameters:
- DATA_W, 32, register and operand width
- PC_W, 16, program counter width
- REG_NUM, 16, register count (address width 4)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- inst_v_i  in  1  fetch presents a valid instruction
- inst_i  in  32  instruction word
- pc_i  in  PC_W  address of inst_i
- stall_o  out  1  fetch must hold inst_i/pc_i next cycle
- stall_i  in  1  execute stall (branch at execute input)
- branch_en_i  in  1  execute: branch taken, squash
- wb_en_i  in  1  execute write-back enable
- wb_addr_i  in  4  write-back register
- wb_data_i  in  DATA_W  write-back data
- rd_value_o, rs_value_o, imm_value_o  out  DATA_W  operands
- rd_addr_o  out  4  destination / condition field
- pc_value_o  out  PC_W  pc of issued instruction
- opcode_o  out  7  opcode
- ctrl_inte_o, ctrl_logic_o, ctrl_shift_o, ctrl_ld_o, ctrl_st_o, ctrl_br_o  out  1 each  class one-hot
- immf_o  out  1  immediate operand select
- rsv_o  out  1  instruction writes rd

Behaviour:
- Instruction format: opcode = inst[31:25]; rd = inst[24:21]; rs = inst[20:17]; immf = inst[16]; imm16 = inst[15:0].
- Class from opcode[6:4]:
  - 000 inte, 001 logic, 010 shift, 011 ld, 100 st, 101 br.
  - 110 and 111 decode to a bubble: consumed and not stalled, but issued as a bubble.
- rsv = 1 for inte, logic, shift and ld. It is 0 for st and br.
- imm_value: zero-extended imm16 for the logic class. All other classes sign-extend imm16.
- Register file: 16 x DATA_W, all zero on reset.
  - Written at the clock edge when wb_en_i is high.
  - Read is combinational on rd and rs.
  - Write-read bypass: if wb_en_i and wb_addr_i equals the read address, return wb_data_i.
- Scoreboard: pending[15:0], cleared on reset.
  - An issue with rsv=1 sets pending[rd].
  - wb_en_i clears pending[wb_addr_i].
  - Set and clear of the same bit in one cycle: the set wins.
- hazard is raised when a source is busy. A source a is busy if pending[a] is set and the cycle is not (wb_en_i and wb_addr_i==a).
  - Sources checked: rd is always checked, because execute uses rd as operand 0 and as the branch condition field.
  - rs is checked only when immf=0.
- issue = inst_v_i & !stall_i & !hazard & !branch_en_i & valid class.
- stall_o = inst_v_i & !branch_en_i & (stall_i | hazard). This path is combinational.
- The output register updates every clock, because execute never holds.
  - On issue it loads the decoded fields. Otherwise it loads a bubble.
  - Bubble: all ctrl_*, rsv_o and immf_o are 0. Operands, addresses, opcode and pc are also 0.
- branch_en_i: the held fetch instruction is dropped, not issued and not stalled. Fetch redirects itself. The scoreboard is untouched.
- Latency: one edge from issue to execute input. A dependent back-to-back instruction stalls exactly one cycle; the bypass satisfies it when the write-back arrives.
- Reset, asserted at any time: all outputs 0 (bubble), stall_o 0, register file 0, pending 0. In-flight state is lost.

Test Plan:
- Reset mid-stream.
  - Stimulus: run instructions, then assert rst low for one cycle.
  - Response: all outputs 0 immediately; after release, r3 reads 0 and no stall occurs.
- Write-back then read.
  - Stimulus: wb_en_i=1, wb_addr_i=5, wb_data_i=0x1234_5678; next cycle issue inte rd=5, rs=2, immf=0.
  - Response: rd_value_o=0x12345678, rs_value_o=0, ctrl_inte_o=1, rsv_o=1.
- RAW interlock.
  - Stimulus: issue add r1; the next instruction reads r1.
  - Response: stall_o=1 for exactly one cycle with one bubble output. On the write-back cycle the bypass supplies r1 and the instruction issues.
- Immediate extension.
  - Stimulus: inte with immf=1, imm16=0xFFFE.
  - Response: imm_value_o=0xFFFFFFFE, and rs pending does not stall.
  - Stimulus: logic with imm16=0xFFFE.
  - Response: imm_value_o=0x0000FFFE.
- Branch sequence.
  - Stimulus: issue br. The next cycle stall_i=1; the following cycle branch_en_i=1.
  - Response: bubble output during stall_i with stall_o=1. With branch_en_i the held instruction is squashed: bubble output, stall_o=0.
- Simultaneous set and clear.
  - Stimulus: wb_en_i clears r4 in the same cycle that a new rd=4 instruction issues.
  - Response: pending[4] stays 1, and a later reader of r4 stalls until the next write-back.
